pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Supervises the multi-output clock PLL: drives its reset, qualifies its `locked` flag, and releases downstream clock-domain resets in a staggered order once lock is stable.
- Retries on lock timeout, flags a fault after repeated failures, and re-sequences on lock loss.
- Sits beside the PLL wrapper in the clock-generation tree. Runs entirely on the PLL reference clock, so it works while PLL outputs are absent.

Parameters:
- RST_HOLD_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry
- LOCK_STABLE, 256, consecutive synchronized-locked cycles required before release
- N_DOMAINS, 4, number of downstream reset outputs
- STAGGER, 8, cycles between successive domain reset releases (>=1)
- MAX_RETRIES, 7, timeout retries permitted before FAULT

Ports:
- refclk  input  1  reference clock (only clock in the block)
- rst  input  1  reset; asynchronous, active-high
- locked  input  1  PLL lock flag, asynchronous to refclk
- soft_reset  input  1  single-cycle request to restart the sequence
- pll_rst  output  1  reset to the PLL, active-high
- domain_rst  output  N_DOMAINS  per-domain resets, active-high; bit 0 released first
- ready  output  1  all domains released, PLL locked
- fault  output  1  retries exhausted
- retry_count  output  $clog2(MAX_RETRIES+1)  timeouts in the current sequence

Behaviour:
- Synchronization: `locked` passes through a 2-flop synchronizer to produce locked_s (2-cycle latency).
- All outputs are registered.
- Reset values (async rst): state=HOLD, counters=0, pll_rst=1, domain_rst=all 1s, ready=0, fault=0, retry_count=0.
- Rst asserted in any state takes effect immediately (async). The sequence restarts from HOLD on deassertion.
- HOLD:
  - pll_rst=1, domain_rst all 1s.
  - After RST_HOLD_CYCLES cycles, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - pll_rst=0.
  - locked_s=1: go to STABLE, clear the counter.
  - Counter reaches LOCK_TIMEOUT-1 without lock:
    - if retry_count==MAX_RETRIES, go to FAULT;
    - else increment retry_count and go to HOLD.
- STABLE:
  - locked_s=0: return to WAIT_LOCK with the timeout counter restarted at 0 (retry_count unchanged).
  - LOCK_STABLE consecutive cycles: go to RELEASE.
- RELEASE:
  - domain_rst[i] clears at i*STAGGER cycles after entry; bit 0 clears on the first RELEASE cycle.
  - After bit N_DOMAINS-1 clears, go to RUN and set ready=1 in the same cycle bit N_DOMAINS-1 clears.
- RUN: holds domain_rst=0 and ready=1.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - next cycle: domain_rst all 1s, ready=0, state=HOLD;
  - retry_count cleared to 0, because lock loss is not a timeout.
- FAULT:
  - pll_rst=1, domain_rst all 1s, fault=1.
  - Stays in FAULT until soft_reset or rst.
- soft_reset:
  - From any state: next cycle state=HOLD, retry_count=0, fault=0, all resets asserted.
  - Has priority over every lock or timeout event in the same cycle.
- Counters: one shared counter, wide enough for max(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, (N_DOMAINS-1)*STAGGER+1). Never wraps; cleared on every state change.

Optional Feature:
- Macro: PLL_LOCK_LOSS_COUNT_EN.
- Defined:
  - adds output lock_loss_count [7:0];
  - increments on each lock-loss event in RELEASE/RUN and saturates at 255;
  - cleared only by rst, not by soft_reset.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
Bench parameters: RST_HOLD_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, N_DOMAINS=4, STAGGER=2, MAX_RETRIES=2.
- Nominal: release rst, locked=1 from cycle 10 -> pll_rst high 4 cycles; domain_rst steps 1110, 1100, 1000, 0000 at 2-cycle spacing; ready=1 together with 0000; retry_count=0.
- Timeouts: locked held 0 -> three pll_rst pulses, retry_count 0→1→2; after the third 32-cycle wait, fault=1, pll_rst=1, domain_rst=1111.
- Glitch in STABLE: locked drops 1 cycle after 5 stable cycles -> domain_rst stays 1111; the 8-cycle qualification restarts; release follows 8 clean cycles after relock.
- Lock loss in RUN: locked falls -> within 3 cycles, domain_rst=1111 and ready=0; new pll_rst pulse of 4 cycles; retry_count=0; lock_loss_count=1 when PLL_LOCK_LOSS_COUNT_EN is defined.
- soft_reset in FAULT, coincident with locked=1 -> fault=0, retry_count=0, state HOLD (pll_rst=1 for 4 cycles); normal sequence follows.
- Async rst mid-RELEASE (domain_rst=1100) -> same timestep: domain_rst=1111, pll_rst=1, ready=0, with no clock edge required.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: holds the PLL in reset, qualifies its lock flag, then releases
// the downstream domain resets one by one. Optional lock-loss counter: PLL_LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 4096,
    parameter int LOCK_STABLE     = 256,
    parameter int N_DOMAINS       = 4,
    parameter int STAGGER         = 8,
    parameter int MAX_RETRIES     = 7
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               locked,
    input  logic                               soft_reset,
    output logic                               pll_rst,
    output logic [N_DOMAINS-1:0]               domain_rst,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]                         lock_loss_count
`endif
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LAST_REL = (N_DOMAINS - 1) * STAGGER;
    localparam int CNT_MAX  = max2(max2(RST_HOLD_CYCLES, LOCK_TIMEOUT), max2(LOCK_STABLE, LAST_REL + 1));
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int RC_W     = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(LAST_REL - 1);
    localparam logic [RC_W-1:0]  MAX_R       = RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [RC_W-1:0]      retry_reg, retry_next;
    logic                 locked_meta_reg, locked_s_reg;
    logic                 pll_rst_reg, ready_reg, fault_reg;
    logic [N_DOMAINS-1:0] domain_rst_reg, domain_rst_next;

    // locked comes straight from the PLL with no relation to refclk
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_meta_reg <= 1'b0;
            locked_s_reg    <= 1'b0;
        end else begin
            locked_meta_reg <= locked;
            locked_s_reg    <= locked_meta_reg;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_HOLD;
            cnt_reg        <= '0;
            retry_reg      <= '0;
            pll_rst_reg    <= 1'b1;
            domain_rst_reg <= '1;
            ready_reg      <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            retry_reg      <= retry_next;
            pll_rst_reg    <= (state_next == S_HOLD) || (state_next == S_FAULT);
            domain_rst_reg <= domain_rst_next;
            ready_reg      <= (state_next == S_RUN);
            fault_reg      <= (state_next == S_FAULT);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        if (soft_reset) begin
            state_next = S_HOLD;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                S_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_next = S_WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s_reg) begin
                        state_next = S_STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retry_reg == MAX_R) begin
                            state_next = S_FAULT;
                        end else begin
                            state_next = S_HOLD;
                            retry_next = retry_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s_reg) begin
                        state_next = S_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        // a single domain has nothing to stagger, so go straight to RUN
                        state_next = (LAST_REL == 0) ? S_RUN : S_RELEASE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!locked_s_reg) begin
                        state_next = S_HOLD;
                        cnt_next   = '0;
                        retry_next = '0;
                    end else if (cnt_reg == REL_LAST) begin
                        state_next = S_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s_reg) begin
                        state_next = S_HOLD;
                        cnt_next   = '0;
                        retry_next = '0;
                    end
                end
                S_FAULT: begin
                    state_next = S_FAULT;
                end
                default: begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                    retry_next = '0;
                end
            endcase
        end
    end

    // Domain gi is released once the RELEASE counter reaches gi*STAGGER
    for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_dom
        if (gi == 0) begin : g_first
            assign domain_rst_next[gi] = !((state_next == S_RUN) || (state_next == S_RELEASE));
        end else begin : g_rest
            localparam logic [CNT_W-1:0] REL_AT = CNT_W'(gi * STAGGER);
            assign domain_rst_next[gi] = !((state_next == S_RUN) ||
                                           ((state_next == S_RELEASE) && (cnt_next >= REL_AT)));
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic       lock_loss;
    logic [7:0] lock_loss_count_reg;

    assign lock_loss = !soft_reset && !locked_s_reg &&
                       ((state_reg == S_RELEASE) || (state_reg == S_RUN));

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_count_reg <= 8'd0;
        end else if (lock_loss && (lock_loss_count_reg != 8'hFF)) begin
            lock_loss_count_reg <= lock_loss_count_reg + 8'd1;
        end
    end

    assign lock_loss_count = lock_loss_count_reg;
`endif

    assign pll_rst     = pll_rst_reg;
    assign domain_rst  = domain_rst_reg;
    assign ready       = ready_reg;
    assign fault       = fault_reg;
    assign retry_count = retry_reg;

endmodule
